uart_tx_top: RTL and testbench



---
 rtl/uart_tx_top.sv | 135 +++++++++++++
 tb/tb_uart_tx_top.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_top.sv
// uart_tx_top: 8N1 UART transmitter.
// Serialises a byte as one start bit, eight data bits LSB first and one
// stop bit. Each bit is held for BIT_CYCLES clocks. RX232 and over_rx are
// both driven straight from flops, so no input reaches an output
// combinationally.
module uart_tx_top #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_en,
  input  logic [7:0] data_rx,
  output logic       RX232,
  output logic       over_rx
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_over;

  logic [1:0]       w_state_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [2:0]       w_idx_n;
  logic [7:0]       w_shift_n;
  logic             w_tx_n;
  logic             w_over_n;
  logic             w_bit_done;

  // The current bit period ends on the last baud count.
  assign w_bit_done = (r_cnt == CNT_LAST);

  // Next-state logic. The line value for the next bit is computed here and
  // registered on the same edge as the state change, so RX232 moves together
  // with the state.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_over_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = CNT_ZERO;
        if (send_en) begin
          w_shift_n = data_rx;
          w_idx_n   = 3'd0;
          w_tx_n    = 1'b0;
          w_state_n = S_START;
        end else begin
          w_tx_n    = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_cnt_n   = CNT_ZERO;
          w_idx_n   = 3'd0;
          w_tx_n    = r_shift[0];
          w_state_n = S_DATA;
        end else begin
          w_cnt_n   = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_cnt_n = CNT_ZERO;
          if (r_idx == 3'd7) begin
            w_tx_n    = 1'b1;
            w_state_n = S_STOP;
          end else begin
            w_idx_n   = r_idx + 3'd1;
            w_tx_n    = r_shift[r_idx + 3'd1];
          end
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_cnt_n   = CNT_ZERO;
          w_tx_n    = 1'b1;
          w_over_n  = 1'b1;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_n   = CNT_ZERO;
        w_idx_n   = 3'd0;
        w_tx_n    = 1'b1;
        w_state_n = S_IDLE;
      end
    endcase
  end

  // State, counters, latched byte and registered outputs; an asynchronous
  // reset abandons any frame and forces the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_over  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_over  <= w_over_n;
    end
  end

  assign RX232   = r_tx;
  assign over_rx = r_over;

endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top: directed and randomized frames against a bit-level model.
// The model builds the 10-bit frame {stop, data, start} and picks the bit
// that a given cycle offset falls into.
module tb_uart_tx_top;

  localparam int BC_S = 16;
  localparam int BC_D = 5208;

  logic       clk;
  logic       rst_n;
  logic       send_en;
  logic [7:0] data_rx;
  logic       RX232;
  logic       over_rx;
  logic       send_en_d;
  logic [7:0] data_rx_d;
  logic       RX232_d;
  logic       over_rx_d;

  int n_checks;
  int n_errors;
  int cyc;

  uart_tx_top #(.CLK_FREQ(160), .BAUD_RATE(10)) dut_s (
    .clk(clk), .rst_n(rst_n), .send_en(send_en), .data_rx(data_rx),
    .RX232(RX232), .over_rx(over_rx)
  );

  uart_tx_top dut_d (
    .clk(clk), .rst_n(rst_n), .send_en(send_en_d), .data_rx(data_rx_d),
    .RX232(RX232_d), .over_rx(over_rx_d)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level c cycles after the accepting edge (c = 1..10*bc).
  function automatic logic exp_line(input logic [7:0] d, input int c, input int bc);
    logic [9:0] frame;
    int k;
    frame = {1'b1, d, 1'b0};
    k = (c - 1) / bc;
    return frame[k];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_errors = n_errors + 1;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_errors = n_errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called one cycle after the accepting edge E; returns in the over_rx cycle.
  task automatic frame_small(input logic [7:0] d, input bit hold,
                             input logic [7:0] nd, output int t_over);
    for (int c = 1; c <= 10 * BC_S; c++) begin
      chk($sformatf("line d=%02h c=%0d", d, c), RX232, exp_line(d, c, BC_S));
      chk($sformatf("over_low d=%02h c=%0d", d, c), over_rx, 1'b0);
      if (c == 1 && !hold) send_en = 1'b0;
      if (c == 80) data_rx = nd;
      step();
    end
    chk($sformatf("over_pulse d=%02h", d), over_rx, 1'b1);
    chk($sformatf("over_line d=%02h", d), RX232, 1'b1);
    t_over = cyc;
  endtask

  task automatic idle_small(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_line", RX232, 1'b1);
      chk("idle_over", over_rx, 1'b0);
    end
  endtask

  initial begin
    int t1;
    int t2;
    logic [7:0] rd;
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    send_en   = 1'b1;
    data_rx   = 8'h49;
    send_en_d = 1'b1;
    data_rx_d = 8'h49;

    // Reset held with a pending request: line stays idle.
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_line", RX232, 1'b1);
      chk("rst_over", over_rx, 1'b0);
      chk("rst_line_d", RX232_d, 1'b1);
      chk("rst_over_d", over_rx_d, 1'b0);
    end
    send_en   = 1'b0;
    send_en_d = 1'b0;
    rst_n     = 1'b1;
    step();
    step();

    // Default parameters: one 8'h49 frame at 5208 cycles per bit.
    send_en_d = 1'b1;
    step();
    send_en_d = 1'b0;
    for (int c = 1; c <= 10 * BC_D; c++) begin
      if (c <= BC_D + 1 || c % BC_D == 0 || c % BC_D == 1) begin
        chk($sformatf("dline c=%0d", c), RX232_d, exp_line(8'h49, c, BC_D));
      end
      if (RX232_d !== exp_line(8'h49, c, BC_D))
        chk($sformatf("dline_mid c=%0d", c), RX232_d, exp_line(8'h49, c, BC_D));
      if (over_rx_d !== 1'b0) chk($sformatf("dover_low c=%0d", c), over_rx_d, 1'b0);
      step();
    end
    chk("dover_pulse", over_rx_d, 1'b1);
    chk("dover_line", RX232_d, 1'b1);
    step();
    chk("dover_single", over_rx_d, 1'b0);

    // Single frame 8'h49, one-cycle request.
    data_rx = 8'h49;
    send_en = 1'b1;
    step();
    frame_small(8'h49, 1'b0, 8'h49, t1);
    idle_small(3);

    // Held request with mid-frame data change.
    send_en = 1'b1;
    data_rx = 8'h49;
    step();
    frame_small(8'h49, 1'b1, 8'hA5, t1);
    step();
    frame_small(8'hA5, 1'b0, 8'hA5, t2);
    chk_int("over_spacing", t2 - t1, 10 * BC_S + 1);
    idle_small(2);

    // Boundary bytes.
    data_rx = 8'h00;
    send_en = 1'b1;
    step();
    frame_small(8'h00, 1'b0, 8'h00, t1);
    idle_small(1);
    data_rx = 8'hFF;
    send_en = 1'b1;
    step();
    frame_small(8'hFF, 1'b0, 8'hFF, t1);
    idle_small(1);

    // Random bytes, with random data churn and random idle gaps.
    for (int f = 0; f < 5; f++) begin
      rd = 8'($urandom);
      data_rx = rd;
      send_en = 1'b1;
      step();
      frame_small(rd, 1'b0, 8'($urandom), t1);
      idle_small(int'($urandom_range(1, 12)));
    end

    // Reset during data bit 3 of an 8'h00 frame.
    data_rx = 8'h00;
    send_en = 1'b1;
    step();
    send_en = 1'b0;
    for (int c = 1; c < 4 * BC_S + 6; c++) begin
      chk($sformatf("pre_rst c=%0d", c), RX232, exp_line(8'h00, c, BC_S));
      step();
    end
    chk("pre_rst_low", RX232, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_line", RX232, 1'b1);
    chk("async_rst_over", over_rx, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12 * BC_S; i++) begin
      step();
      if (i < 4 || RX232 !== 1'b1) chk($sformatf("post_rst_line i=%0d", i), RX232, 1'b1);
      if (i < 4 || over_rx !== 1'b0) chk($sformatf("post_rst_over i=%0d", i), over_rx, 1'b0);
    end

    // After reset the block sends normally again.
    data_rx = 8'h3C;
    send_en = 1'b1;
    step();
    frame_small(8'h3C, 1'b0, 8'h3C, t1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
